// File: rtl/hack_dpram.sv
// hack_dpram: parameterised dual-port synchronous RAM for the Hack CPU.
// Port A is the CPU read/write port; port B is the read-only video scanout port.
// A clear sequencer writes CLEAR_VAL to every word after each reset; ready goes
// high once the sweep finishes.
// Optional feature macro: RAM_FWD_EN (port A write-first). When it is undefined,
// port A is read-first. Port B is always read-first.
module hack_dpram #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 14,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  input  logic [ADDR_W-1:0] b_address,
  output logic [DATA_W-1:0] b_out,
  output logic              ready
);

  localparam int              DEPTH = 1 << ADDR_W;
  // The pointer is one bit wider than the address so the terminal compare cannot alias.
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Next state and a single write port: the clear sweep owns it in CLEAR, the CPU in RUN.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = address;
    wdata     = in;
    case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = ptr[ADDR_W-1:0];
        wdata = CLEAR_VAL;
        if (ptr == LAST) state_nxt = S_RUN;
      end
      S_RUN:   we = load;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // State, clear pointer, and a registered ready flag that tracks entry into RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == S_RUN);
      if (state == S_CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // Array write. The array has no reset, and it is left untouched while reset is asserted.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  // Registered read ports. Both outputs are held at zero while reset is asserted and
  // during the clear sweep. Port B always returns the pre-write word.
  always_ff @(posedge clk) begin
    if (reset || state != S_RUN) begin
      out   <= '0;
      b_out <= '0;
    end else begin
`ifdef RAM_FWD_EN
      out   <= load ? in : mem[address];
`else
      out   <= mem[address];
`endif
      b_out <= mem[b_address];
    end
  end

endmodule

// File: tb/tb_hack_dpram.sv
// Self-checking bench for hack_dpram. It uses a small DUT (ADDR_W=4) for directed and
// random tests and a full-size DUT (ADDR_W=14, CLEAR_VAL=FFFF) for the long clear.
// Expected read data is pushed to per-port queues when a cycle is driven, then popped
// and compared after the next clock edge.
module tb_hack_dpram;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [3:0]  address, b_address;
  logic [15:0] out, b_out;
  logic        ready;

  logic        big_reset;
  logic [15:0] big_in;
  logic        big_load;
  logic [13:0] big_address, big_b_address;
  logic [15:0] big_out, big_b_out;
  logic        big_ready;

  int errors = 0;
  int checks = 0;

  // Each queue entry: bit 16 = compare enable, bits 15:0 = expected value.
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic [15:0] model [16];

  always #5 clk = ~clk;

  hack_dpram #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
    .out(out), .b_address(b_address), .b_out(b_out), .ready(ready)
  );

  hack_dpram #(.DATA_W(16), .ADDR_W(14), .CLEAR_VAL(16'hFFFF)) u_big (
    .clk(clk), .reset(big_reset), .in(big_in), .load(big_load), .address(big_address),
    .out(big_out), .b_address(big_b_address), .b_out(big_b_out), .ready(big_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then pop and compare the entries produced by that edge.
  task automatic step(input string tag);
    logic [16:0] ea, eb;
    @(posedge clk); #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      if (ea[16]) chk({tag, ".out"}, out, ea[15:0]);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      if (eb[16]) chk({tag, ".b_out"}, b_out, eb[15:0]);
    end
  endtask

  // Drive one cycle. When run=0 the DUT is clearing: the write must be dropped and
  // both outputs must read 0.
  task automatic go(input string tag, input logic [3:0] a, input logic ld,
                    input logic [15:0] d, input logic [3:0] b, input logic run);
    logic [15:0] ea;
    address = a; load = ld; in = d; b_address = b;
    if (run) begin
`ifdef RAM_FWD_EN
      ea = ld ? d : model[a];
`else
      ea = model[a];
`endif
      qa.push_back({1'b1, ea});
      qb.push_back({1'b1, model[b]});
      if (ld) model[a] = d;
    end else begin
      qa.push_back({1'b1, 16'h0000});
      qb.push_back({1'b1, 16'h0000});
    end
    step(tag);
  endtask

  // Assert reset for one cycle and check the held-at-zero outputs.
  task automatic do_reset(input string tag);
    reset = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rst_out"},   out,   16'h0000);
    chk({tag, ".rst_b_out"}, b_out, 16'h0000);
    chk({tag, ".rst_ready"}, {15'd0, ready}, 16'h0000);
    reset = 1'b0;
  endtask

  // Count the edges until ready rises, bounded so that a stuck DUT cannot hang the run.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".clear_cycles"}, 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; in = '0; address = '0; b_address = '0;
    big_reset = 1'b1; big_load = 1'b0; big_in = '0; big_address = '0; big_b_address = '0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    // Bring the DUT up once, then fill every word with garbage before the reset under test.
    do_reset("init");
    wait_ready("init");
    for (int i = 0; i < 16; i++) go("garbage", 4'(i), 1'b1, 16'hA500 + 16'(i), 4'(i), 1'b1);

    // 1: reset, clear, then read every word on both ports.
    do_reset("t1");
    wait_ready("t1");
    chk("t1.ready", {15'd0, ready}, 16'h0001);
    for (int i = 0; i < 16; i++) go("t1.rd", 4'(i), 1'b0, 16'h0, 4'(15 - i), 1'b1);

    // 2: write, then read back on both ports.
    go("t2.wr", 4'd3, 1'b1, 16'hBEEF, 4'd0, 1'b1);
    go("t2.rd", 4'd3, 1'b0, 16'h0,    4'd3, 1'b1);

    // 3: same-cycle write and port B read of one address.
    go("t3.pre", 4'd5, 1'b1, 16'hBEEF, 4'd0, 1'b1);
    go("t3.wr",  4'd5, 1'b1, 16'h1234, 4'd5, 1'b1);
    go("t3.nxt", 4'd0, 1'b0, 16'h0,    4'd5, 1'b1);

    // Random traffic in RUN.
    for (int i = 0; i < 40; i++)
      go("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         16'($urandom), 4'($urandom_range(0, 15)), 1'b1);

    // 4: writes attempted during the clear are dropped. Address 0 is written after the
    // sweep has already passed it.
    do_reset("t4");
    go("t4.c1", 4'd0, 1'b0, 16'h0,    4'd0, 1'b0);
    go("t4.c2", 4'd0, 1'b0, 16'h0,    4'd0, 1'b0);
    go("t4.c3", 4'd7, 1'b1, 16'hAAAA, 4'd7, 1'b0);
    go("t4.c4", 4'd0, 1'b1, 16'h5555, 4'd0, 1'b0);
    load = 1'b0;
    n = 4;
    while (!ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("t4.clear_cycles", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    go("t4.rd7", 4'd7, 1'b0, 16'h0, 4'd0, 1'b1);
    go("t4.rd0", 4'd0, 1'b0, 16'h0, 4'd7, 1'b1);

    // 5: reset in the middle of the clear restarts the full sweep.
    do_reset("t5a");
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t5.mid_ready", {15'd0, ready}, 16'h0000);
    do_reset("t5b");
    wait_ready("t5");
    go("t5.rd", 4'd9, 1'b0, 16'h0, 4'd2, 1'b1);

    // 6: full-size array with CLEAR_VAL = FFFF.
    @(posedge clk); #1;
    chk("t6.rst_ready", {15'd0, big_ready}, 16'h0000);
    big_reset = 1'b0;
    n = 0;
    while (!big_ready && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk("t6.clear_cycles", 16'(n), 16'd16384);
    for (int i = 0; i < 6; i++) begin
      big_address = 14'($urandom); big_b_address = 14'($urandom);
      @(posedge clk); #1;
      chk("t6.out",   big_out,   16'hFFFF);
      chk("t6.b_out", big_b_out, 16'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
